// File: rtl/wb_data_upsize.sv
// Bridges an 8-bit Wishbone master onto a 32-bit Wishbone slave with a one-word read buffer.
// Big-endian lane order: byte address 0 occupies bits 31:24 of the slave word.
module wb_data_upsize #(
    parameter int unsigned aw     = 32,
    parameter bit          rd_buf = 1'b1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic [aw-1:0] wbm_adr_i,
    input  logic [7:0]    wbm_dat_i,
    input  logic          wbm_we_i,
    input  logic          wbm_cyc_i,
    input  logic          wbm_stb_i,
    input  logic [2:0]    wbm_cti_i,
    input  logic [1:0]    wbm_bte_i,
    output logic [7:0]    wbm_sdt_o,
    output logic          wbm_ack_o,
    output logic          wbm_err_o,
    output logic          wbm_rty_o,
    output logic [aw-1:0] wbs_adr_o,
    output logic [31:0]   wbs_dat_o,
    output logic [3:0]    wbs_sel_o,
    output logic          wbs_we_o,
    output logic          wbs_cyc_o,
    output logic          wbs_stb_o,
    output logic [2:0]    wbs_cti_o,
    output logic [1:0]    wbs_bte_o,
    input  logic [31:0]   wbs_sdt_i,
    input  logic          wbs_ack_i,
    input  logic          wbs_err_i,
    input  logic          wbs_rty_i,
    input  logic          inv_i
);

    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

    state_t        state_q, state_d;
    logic          buf_valid_q, buf_valid_d;
    logic [aw-3:0] buf_tag_q, buf_tag_d;
    logic [31:0]   buf_data_q, buf_data_d;
    logic [aw-3:0] req_tag_q, req_tag_d;
    logic [1:0]    req_lane_q, req_lane_d;
    logic [7:0]    req_dat_q, req_dat_d;

    logic          m_ack_d, m_err_d, m_rty_d;
    logic [7:0]    m_sdt_d;
    logic          s_cyc_q, s_cyc_d, s_we_d;
    logic [3:0]    s_sel_d;
    logic [31:0]   s_dat_d;
    logic [aw-1:0] s_adr_d;

    logic          hit;
    logic          tag_match;
    logic          unused_inputs;

    assign unused_inputs = ^{wbm_cti_i, wbm_bte_i};

    assign wbs_cyc_o = s_cyc_q;
    assign wbs_stb_o = s_cyc_q;
    assign wbs_cti_o = '0;
    assign wbs_bte_o = '0;

    assign hit       = rd_buf && buf_valid_q && (buf_tag_q == wbm_adr_i[aw-1:2]);
    assign tag_match = buf_valid_q && (buf_tag_q == req_tag_q);

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
        case (lane)
            2'd0:    lane_byte = w[31:24];
            2'd1:    lane_byte = w[23:16];
            2'd2:    lane_byte = w[15:8];
            default: lane_byte = w[7:0];
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [7:0] b);
        lane_merge = w;
        case (lane)
            2'd0:    lane_merge[31:24] = b;
            2'd1:    lane_merge[23:16] = b;
            2'd2:    lane_merge[15:8]  = b;
            default: lane_merge[7:0]   = b;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        req_tag_d   = req_tag_q;
        req_lane_d  = req_lane_q;
        req_dat_d   = req_dat_q;
        m_ack_d     = 1'b0;
        m_err_d     = 1'b0;
        m_rty_d     = 1'b0;
        m_sdt_d     = wbm_sdt_o;
        s_cyc_d     = s_cyc_q;
        s_we_d      = wbs_we_o;
        s_sel_d     = wbs_sel_o;
        s_dat_d     = wbs_dat_o;
        s_adr_d     = wbs_adr_o;

        case (state_q)
            IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    req_tag_d  = wbm_adr_i[aw-1:2];
                    req_lane_d = wbm_adr_i[1:0];
                    req_dat_d  = wbm_dat_i;
                    if (wbm_we_i) begin
                        state_d = WR;
                        s_cyc_d = 1'b1;
                        s_we_d  = 1'b1;
                        s_sel_d = 4'b1000 >> wbm_adr_i[1:0];
                        s_dat_d = {4{wbm_dat_i}};
                        s_adr_d = {wbm_adr_i[aw-1:2], 2'b00};
                    end else if (hit) begin
                        state_d = ACK;
                        m_ack_d = 1'b1;
                        m_sdt_d = lane_byte(buf_data_q, wbm_adr_i[1:0]);
                    end else begin
                        state_d = RD;
                        s_cyc_d = 1'b1;
                        s_we_d  = 1'b0;
                        s_sel_d = 4'hF;
                        s_adr_d = {wbm_adr_i[aw-1:2], 2'b00};
                    end
                end
            end
            RD: begin
                // A master abort wins over any slave response arriving in the same cycle.
                if (!wbm_cyc_i) begin
                    state_d = IDLE;
                    s_cyc_d = 1'b0;
                    s_we_d  = 1'b0;
                end else if (wbs_err_i) begin
                    state_d     = ACK;
                    s_cyc_d     = 1'b0;
                    m_err_d     = 1'b1;
                    buf_valid_d = 1'b0;
                end else if (wbs_ack_i) begin
                    state_d     = ACK;
                    s_cyc_d     = 1'b0;
                    m_ack_d     = 1'b1;
                    m_sdt_d     = lane_byte(wbs_sdt_i, req_lane_q);
                    buf_data_d  = wbs_sdt_i;
                    buf_tag_d   = req_tag_q;
                    buf_valid_d = 1'b1;
                end else if (wbs_rty_i) begin
                    state_d = ACK;
                    s_cyc_d = 1'b0;
                    m_rty_d = 1'b1;
                end
            end
            WR: begin
                if (!wbm_cyc_i) begin
                    state_d = IDLE;
                    s_cyc_d = 1'b0;
                    s_we_d  = 1'b0;
                end else if (wbs_err_i) begin
                    state_d = ACK;
                    s_cyc_d = 1'b0;
                    s_we_d  = 1'b0;
                    m_err_d = 1'b1;
                    if (tag_match) buf_valid_d = 1'b0;
                end else if (wbs_ack_i) begin
                    state_d = ACK;
                    s_cyc_d = 1'b0;
                    s_we_d  = 1'b0;
                    m_ack_d = 1'b1;
                    if (tag_match) buf_data_d = lane_merge(buf_data_q, req_lane_q, req_dat_q);
                end else if (wbs_rty_i) begin
                    state_d = ACK;
                    s_cyc_d = 1'b0;
                    s_we_d  = 1'b0;
                    m_rty_d = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Invalidate overrides any buffer load decided above, including a read fill.
        if (inv_i) buf_valid_d = 1'b0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= IDLE;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            req_tag_q   <= '0;
            req_lane_q  <= '0;
            req_dat_q   <= '0;
            wbm_ack_o   <= 1'b0;
            wbm_err_o   <= 1'b0;
            wbm_rty_o   <= 1'b0;
            wbm_sdt_o   <= '0;
            s_cyc_q     <= 1'b0;
            wbs_we_o    <= 1'b0;
            wbs_sel_o   <= '0;
            wbs_dat_o   <= '0;
            wbs_adr_o   <= '0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            req_tag_q   <= req_tag_d;
            req_lane_q  <= req_lane_d;
            req_dat_q   <= req_dat_d;
            wbm_ack_o   <= m_ack_d;
            wbm_err_o   <= m_err_d;
            wbm_rty_o   <= m_rty_d;
            wbm_sdt_o   <= m_sdt_d;
            s_cyc_q     <= s_cyc_d;
            wbs_we_o    <= s_we_d;
            wbs_sel_o   <= s_sel_d;
            wbs_dat_o   <= s_dat_d;
            wbs_adr_o   <= s_adr_d;
        end
    end

endmodule

// File: tb/tb_wb_data_upsize.sv
// Bench for wb_data_upsize: directed test-plan steps followed by random traffic,
// checked against a word-level buffer and memory model.
module tb_wb_data_upsize;

    localparam int unsigned AW = 32;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_n_i;
    logic [AW-1:0] wbm_adr_i;
    logic [7:0]    wbm_dat_i;
    logic          wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [2:0]    wbm_cti_i;
    logic [1:0]    wbm_bte_i;
    logic [7:0]    wbm_sdt_o;
    logic          wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [AW-1:0] wbs_adr_o;
    logic [31:0]   wbs_dat_o;
    logic [3:0]    wbs_sel_o;
    logic          wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]    wbs_cti_o;
    logic [1:0]    wbs_bte_o;
    logic [31:0]   wbs_sdt_i;
    logic          wbs_ack_i, wbs_err_i, wbs_rty_i;
    logic          inv_i;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_data_upsize #(.aw(AW), .rd_buf(1'b1)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_we_i(wbm_we_i),
        .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_cti_i(wbm_cti_i),
        .wbm_bte_i(wbm_bte_i), .wbm_sdt_o(wbm_sdt_o), .wbm_ack_o(wbm_ack_o),
        .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
        .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o), .wbs_sdt_i(wbs_sdt_i),
        .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
        .inv_i(inv_i)
    );

    int checks = 0;
    int errors = 0;

    // Reference: slave memory plus the bridge's buffered word.
    logic [31:0] mem [int unsigned];
    logic        m_valid = 1'b0;
    logic [29:0] m_tag   = '0;
    logic [31:0] m_word  = '0;

    localparam logic [2:0] R_ACK = 3'b100, R_ERR = 3'b010, R_RTY = 3'b001, R_NONE = 3'b000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        if (!mem.exists(int'(wa))) mem[int'(wa)] = $urandom;
        return mem[int'(wa)];
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int lane);
        logic [31:0] t;
        t = w >> (8 * (3 - lane));
        return t[7:0];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input int lane, input logic [7:0] b);
        int sh;
        sh = 8 * (3 - lane);
        return (w & ~(32'hFF << sh)) | ({24'h0, b} << sh);
    endfunction

    // kind: 0 ack, 1 err, 2 rty, 3 err+ack together, 4 ack+rty together
    task automatic drive_resp(input int kind);
        wbs_ack_i = (kind == 0 || kind == 3 || kind == 4);
        wbs_err_i = (kind == 1 || kind == 3);
        wbs_rty_i = (kind == 2 || kind == 4);
    endtask

    function automatic logic [2:0] resp_code(input int kind);
        if (kind == 1 || kind == 3) return R_ERR;
        if (kind == 0 || kind == 4) return R_ACK;
        return R_RTY;
    endfunction

    task automatic mread(input logic [31:0] a, input int lat, input int kind, input bit inv_at_resp);
        logic [29:0] wa;
        int          lane;
        bit          hit;
        logic [31:0] w;
        wa   = a[31:2];
        lane = int'(a[1:0]);
        hit  = m_valid && (m_tag == wa);
        w    = mem_word(wa);
        wbm_adr_i = a; wbm_we_i = 1'b0; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        @(negedge wb_clk_i);
        if (hit) begin
            chk("hit_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, R_ACK);
            chk("hit_data", wbm_sdt_o, byte_of(m_word, lane));
            chk("hit_no_slave", wbs_cyc_o, 0);
        end else begin
            chk("rd_ctl", {wbs_cyc_o, wbs_stb_o, wbs_we_o}, 3'b110);
            chk("rd_sel", wbs_sel_o, 4'hF);
            chk("rd_adr", wbs_adr_o, {wa, 2'b00});
            chk("rd_early_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, R_NONE);
            for (int i = 0; i < lat; i++) begin
                @(negedge wb_clk_i);
                chk("rd_wait_stb", wbs_stb_o, 1);
                chk("rd_wait_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, R_NONE);
            end
            wbs_sdt_i = w;
            drive_resp(kind);
            inv_i = inv_at_resp;
            @(negedge wb_clk_i);
            drive_resp(-1);
            inv_i = 1'b0;
            chk("rd_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, resp_code(kind));
            if (resp_code(kind) == R_ACK) chk("rd_data", wbm_sdt_o, byte_of(w, lane));
            chk("rd_slave_drop", {wbs_cyc_o, wbs_stb_o}, 0);
            if (resp_code(kind) == R_ACK) begin
                m_valid = !inv_at_resp; m_tag = wa; m_word = w;
            end else if (resp_code(kind) == R_ERR || inv_at_resp) begin
                m_valid = 1'b0;
            end
        end
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        @(negedge wb_clk_i);
        chk("resp_single_pulse", {wbm_ack_o, wbm_err_o, wbm_rty_o}, R_NONE);
    endtask

    task automatic mwrite(input logic [31:0] a, input logic [7:0] d, input int lat, input int kind);
        logic [29:0] wa;
        int          lane;
        logic [3:0]  exp_sel;
        wa      = a[31:2];
        lane    = int'(a[1:0]);
        exp_sel = 4'b0001 << (3 - lane);
        wbm_adr_i = a; wbm_dat_i = d; wbm_we_i = 1'b1; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        @(negedge wb_clk_i);
        chk("wr_ctl", {wbs_cyc_o, wbs_stb_o, wbs_we_o}, 3'b111);
        chk("wr_sel", wbs_sel_o, exp_sel);
        chk("wr_dat", wbs_dat_o, {d, d, d, d});
        chk("wr_adr", wbs_adr_o, {wa, 2'b00});
        for (int i = 0; i < lat; i++) begin
            @(negedge wb_clk_i);
            chk("wr_wait_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, R_NONE);
        end
        drive_resp(kind);
        @(negedge wb_clk_i);
        drive_resp(-1);
        chk("wr_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, resp_code(kind));
        chk("wr_slave_drop", wbs_cyc_o, 0);
        if (resp_code(kind) == R_ACK) begin
            mem[int'(wa)] = put_byte(mem_word(wa), lane, d);
            if (m_valid && m_tag == wa) m_word = put_byte(m_word, lane, d);
        end else if (resp_code(kind) == R_ERR && m_tag == wa) begin
            m_valid = 1'b0;
        end
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_we_i = 1'b0;
        @(negedge wb_clk_i);
        chk("wr_single_pulse", {wbm_ack_o, wbm_err_o, wbm_rty_o}, R_NONE);
    endtask

    task automatic mread_abort(input logic [31:0] a);
        wbm_adr_i = a; wbm_we_i = 1'b0; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        @(negedge wb_clk_i);
        chk("abort_stb", wbs_stb_o, 1);
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        wbs_sdt_i = $urandom;
        wbs_ack_i = 1'b1;
        @(negedge wb_clk_i);
        wbs_ack_i = 1'b0;
        chk("abort_slave_drop", {wbs_cyc_o, wbs_stb_o}, 0);
        chk("abort_no_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, R_NONE);
        @(negedge wb_clk_i);
        chk("abort_no_late_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, R_NONE);
    endtask

    task automatic inv_pulse();
        inv_i = 1'b1;
        @(negedge wb_clk_i);
        inv_i = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_sdt_o, wbs_cyc_o, wbs_stb_o,
                           wbs_we_o, wbs_sel_o, wbs_cti_o, wbs_bte_o}, 0);
        chk({tag, "_adr"}, wbs_adr_o, 0);
        chk({tag, "_dat"}, wbs_dat_o, 0);
    endtask

    initial begin
        logic [31:0] a;
        int          op, k;

        wb_rst_n_i = 1'b0;
        wbm_adr_i = '0; wbm_dat_i = '0; wbm_we_i = 1'b0; wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        wbm_cti_i = 3'b010; wbm_bte_i = 2'b01;
        wbs_sdt_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0; inv_i = 1'b0;
        #3;
        chk_all_zero("reset");
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;

        // Miss then three hits on one word.
        mem[32'h40] = 32'hA1B2C3D4;
        mread(32'h100, 1, 0, 1'b0);
        chk("first_byte_model", {24'h0, byte_of(mem_word(30'h40), 0)}, 32'hA1);
        mread(32'h101, 0, 0, 1'b0);
        mread(32'h102, 0, 0, 1'b0);
        mread(32'h103, 0, 0, 1'b0);

        // Write-through, then hit returns the new byte.
        mwrite(32'h102, 8'h5E, 0, 0);
        mread(32'h102, 0, 0, 1'b0);

        // Tag change and back.
        mread(32'h104, 2, 0, 1'b0);
        mread(32'h100, 0, 0, 1'b0);

        // Slave error invalidates; re-read goes to the slave.
        mread(32'h200, 0, 1, 1'b0);
        mread(32'h200, 0, 0, 1'b0);

        // Abort leaves the buffer intact.
        mread_abort(32'h300);
        mread(32'h201, 0, 0, 1'b0);

        // Invalidate forces a slave access.
        inv_pulse();
        mread(32'h202, 0, 0, 1'b0);

        // Response priority.
        mread(32'h400, 0, 3, 1'b0);
        mread(32'h401, 1, 4, 1'b0);
        mread(32'h402, 0, 2, 1'b0);

        // Invalidate coinciding with a read fill: data delivered, buffer left invalid.
        mread(32'h503, 0, 0, 1'b1);
        mread(32'h503, 0, 0, 1'b0);

        // Write error on the buffered word invalidates it.
        mwrite(32'h501, 8'h77, 0, 1);
        mread(32'h501, 0, 0, 1'b0);

        // Asynchronous reset in the middle of a slave cycle.
        wbm_adr_i = 32'h600; wbm_we_i = 1'b0; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        @(negedge wb_clk_i);
        chk("pre_reset_stb", wbs_stb_o, 1);
        #2 wb_rst_n_i = 1'b0;
        #1 chk_all_zero("mid_reset");
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        m_valid = 1'b0;
        mread(32'h501, 0, 0, 1'b0);

        // Random traffic over a few neighbouring words.
        for (int n = 0; n < 120; n++) begin
            a  = 32'h100 + ($urandom_range(0, 2) * 4) + $urandom_range(0, 3);
            op = int'($urandom_range(0, 9));
            k  = int'($urandom_range(0, 11));
            if (op < 6) begin
                mread(a, int'($urandom_range(0, 2)), (k > 4) ? 0 : k, ($urandom_range(0, 15) == 0));
            end else if (op < 9) begin
                mwrite(a, 8'($urandom), int'($urandom_range(0, 2)), (k > 2) ? 0 : k);
            end else begin
                inv_pulse();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_data_upsize.md
Name: wb_data_upsize

Overview:
- Bridges an 8-bit Wishbone master onto a 32-bit Wishbone slave.
- Provides a one-word read buffer, so that sequential byte reads within a word cost one slave access.
- Writes go through as byte-lane-selected 32-bit cycles and keep the buffer coherent.
- Sits between narrow initiators (UART-style debug masters, 8-bit CPUs) and the 32-bit intercon.
- Uses big-endian lane order: byte address 0 maps to bits 31:24.

Parameters:
aw, 32, address width
rd_buf, 1, 1 enables the read buffer; 0 makes every read a slave access

Ports:
wb_clk_i  in  1  clock
wb_rst_n_i  in  1  asynchronous active-low reset
wbm_adr_i  in  aw  master byte address
wbm_dat_i  in  8  master write data
wbm_we_i  in  1  write enable
wbm_cyc_i  in  1  cycle
wbm_stb_i  in  1  strobe
wbm_cti_i  in  3  cycle type (ignored; slave side always classic)
wbm_bte_i  in  2  burst type (ignored)
wbm_sdt_o  out  8  read data to master
wbm_ack_o  out  1  acknowledge
wbm_err_o  out  1  error
wbm_rty_o  out  1  retry
wbs_adr_o  out  aw  word address, bits [1:0] always 0
wbs_dat_o  out  32  write data
wbs_sel_o  out  4  byte select
wbs_we_o  out  1  write enable
wbs_cyc_o  out  1  cycle
wbs_stb_o  out  1  strobe
wbs_cti_o  out  3  constant 3'b000
wbs_bte_o  out  2  constant 2'b00
wbs_sdt_i  in  32  slave read data
wbs_ack_i  in  1  slave acknowledge
wbs_err_i  in  1  slave error
wbs_rty_i  in  1  slave retry
inv_i  in  1  invalidate read buffer (volatile region / external write)

Behaviour:
- Reset (wb_rst_n_i low, asynchronous):
  - All outputs 0.
  - State IDLE, buffer valid=0, tag=0, data=0.
- Lane map: adr[1:0] 0/1/2/3 maps to sel 4'b1000/0100/0010/0001 and bits 31:24/23:16/15:8/7:0.
- State IDLE: samples wbm_cyc_i & wbm_stb_i.
  - Read, rd_buf=1, valid=1, tag==adr[aw-1:2] (hit): go to ACK.
    - Next cycle: wbm_ack_o=1, wbm_sdt_o = selected buffer byte.
  - Read otherwise (miss): go to RD.
    - Next cycle: wbs_cyc_o=wbs_stb_o=1, we=0, sel=4'hF, adr={adr[aw-1:2],2'b00}.
  - Write: go to WR.
    - Next cycle: wbs_cyc_o=wbs_stb_o=wbs_we_o=1, sel = one-hot lane.
    - wbs_dat_o = wbm_dat_i replicated on all four lanes.
  - Address, data and lane are latched at request acceptance and held until completion.
- State RD: wait for a slave response.
  - err: drop slave cyc/stb; 1-cycle wbm_err_o pulse; valid=0.
  - ack without err: load buffer data=wbs_sdt_i, tag, valid=1; drop slave cyc/stb.
    - Next cycle: wbm_ack_o with the selected byte of wbs_sdt_i.
  - rty: drop slave cyc/stb; wbm_rty_o pulse; buffer unchanged.
  - Priority when several arrive together: err > ack > rty.
- State WR: wait for a slave response.
  - ack: wbm_ack_o pulse next cycle.
    - If valid and tag matches, the buffer byte in that lane is updated to the written data (write-through).
  - err: wbm_err_o pulse; valid=0 if tag matches.
  - rty: wbm_rty_o pulse.
- State ACK: one cycle driving the master response, then IDLE. No new request is accepted in this cycle.
  - Throughput: one byte every 2 cycles on hits.
- Latency:
  - Hit: wbm_ack_o 1 cycle after request.
  - Miss/write: slave stb 1 cycle after request; wbm_ack_o 1 cycle after wbs_ack_i.
- Master abort: wbm_cyc_i low while in RD/WR.
  - Slave cyc/stb are deasserted the next cycle and state returns to IDLE.
  - No master response is given; buffer is not loaded.
  - A slave ack arriving in the abort cycle is discarded.
- inv_i:
  - Clears valid in any state.
  - Same cycle as an RD slave ack: data is still returned to the master, but valid ends 0.
- wbm_err_o, wbm_rty_o and wbm_ack_o are mutually exclusive, single-cycle pulses.

Test Plan:
- Read miss then hits:
  - Slave word at 0x100 = 0xA1B2C3D4.
  - Master reads 0x100..0x103 -> bytes A1,B2,C3,D4.
  - Exactly one slave cycle (sel=F, adr=0x100); hits acked 1 cycle after stb.
- Write-through:
  - After buffering 0x100, write 0x5E to 0x102.
  - Slave sees sel=4'b0010, dat=0x5E5E5E5E.
  - A subsequent read of 0x102 returns 0x5E with no slave cycle.
- Tag change: read 0x104 after buffering 0x100 -> new slave cycle at adr 0x104; old tag replaced.
- Slave error:
  - Slave asserts err on a read of 0x200 -> wbm_err_o single pulse, valid=0.
  - Re-read of 0x200 issues a slave cycle again.
- Abort and invalidate:
  - Master drops cyc during a pending read -> slave cyc drops next cycle, no master ack, buffer unchanged.
  - inv_i pulse, then read of the buffered word -> slave access.
- Reset mid-cycle: assert wb_rst_n_i low while wbs_stb_o=1 -> all outputs 0 immediately; first post-reset read is a miss.
